// File: rtl/skid_reg_pkg.sv
// Shared state encoding and count decode for the two-entry skid register.
package skid_reg_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        StEmpty = ST_EMPTY,
        StBusy  = ST_BUSY,
        StFull  = ST_FULL
    } skid_state_e;

    // Number of beats held, encoded as 0 / 1 / 2
    function automatic logic [1:0] state_count(input skid_state_e st);
        unique case (st)
            StBusy:  return 2'd1;
            StFull:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/my_reg.sv
// Library enabled data register with synchronous active-high reset.
module my_reg #(
    parameter int unsigned          DATA_W  = 21,
    parameter logic [DATA_W-1:0]    RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= RST_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/skid_reg.sv
// Two-entry valid/ready skid buffer; all outputs decode from registered state only.
module skid_reg
    import skid_reg_pkg::*;
#(
    parameter int unsigned       DATA_W  = 21,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic [1:0]        count_o
);

    skid_state_e       state_q, state_d;
    logic              in_xfer, out_xfer;
    logic              main_en, skid_en, main_from_skid;
    logic [DATA_W-1:0] main_d, skid_q;

    assign s_ready_o = (state_q != StFull);
    assign m_valid_o = (state_q != StEmpty);
    assign count_o   = state_count(state_q);

    assign in_xfer  = s_valid_i & s_ready_o;
    assign out_xfer = m_valid_o & m_ready_i;

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    main_en = 1'b1;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (in_xfer && out_xfer) begin
                    main_en = 1'b1;
                end else if (in_xfer) begin
                    skid_en = 1'b1;
                    state_d = StFull;
                end else if (out_xfer) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (out_xfer) begin
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = StBusy;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    assign main_d = main_from_skid ? skid_q : s_data_i;

    my_reg #(
        .DATA_W  (DATA_W),
        .RST_VAL (RST_VAL)
    ) u_main (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (main_en),
        .d_i   (main_d),
        .q_o   (m_data_o)
    );

    my_reg #(
        .DATA_W  (DATA_W),
        .RST_VAL (RST_VAL)
    ) u_skid (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (skid_en),
        .d_i   (s_data_i),
        .q_o   (skid_q)
    );

endmodule

// File: tb/tb_skid_reg.sv
// Randomized and directed checks of skid_reg against a queue-based FIFO reference.
module tb_skid_reg;

    localparam int unsigned       DW   = 21;
    localparam logic [DW-1:0]     RSTV = '0;

    logic          clk = 1'b0;
    logic          rst, s_valid, s_ready, m_valid, m_ready;
    logic [DW-1:0] s_data, m_data;
    logic [1:0]    count;

    int unsigned n_tests  = 0;
    int unsigned n_failed = 0;

    logic [DW-1:0] model_q[$];
    bit            exp_rst_data = 1'b0;

    always #5 clk = ~clk;

    skid_reg #(
        .DATA_W  (DW),
        .RST_VAL (RSTV)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .s_data_i  (s_data),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_data_o  (m_data),
        .count_o   (count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the FIFO model, then compare all outputs
    task automatic step(input logic r, input logic sv, input logic [DW-1:0] sd,
                        input logic mr);
        bit do_in, do_out;
        rst     = r;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        @(posedge clk);
        if (r) begin
            model_q.delete();
            exp_rst_data = 1'b1;
        end else begin
            do_in  = sv && (model_q.size() < 2);
            do_out = mr && (model_q.size() > 0);
            if (do_out) void'(model_q.pop_front());
            if (do_in) begin
                model_q.push_back(sd);
                exp_rst_data = 1'b0;
            end
        end
        #1;
        check_eq("s_ready", 32'(s_ready), 32'(model_q.size() < 2));
        check_eq("m_valid", 32'(m_valid), 32'(model_q.size() > 0));
        check_eq("count", 32'(count), 32'(model_q.size()));
        if (model_q.size() > 0) begin
            check_eq("m_data", 32'(m_data), 32'(model_q[0]));
        end else if (exp_rst_data) begin
            check_eq("m_data_rst", 32'(m_data), 32'(RSTV));
        end
    endtask

    logic [DW-1:0] held;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

        // Reset with a beat presented: it must be dropped
        step(1'b1, 1'b1, 21'h1, 1'b1);
        step(1'b1, 1'b1, 21'h1, 1'b1);
        check_eq("rst_count", 32'(count), 32'd0);
        step(1'b0, 1'b0, 21'h0, 1'b1);
        check_eq("rst_no_beat", 32'(m_valid), 32'd0);

        // Streaming at full rate
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, DW'(32'h10 + i), 1'b1);
            check_eq("stream_cnt", 32'(count), 32'd1);
        end
        step(1'b0, 1'b0, 21'h0, 1'b1);

        // Stall into FULL, hold, then release
        step(1'b0, 1'b1, 21'hA1, 1'b1);
        step(1'b0, 1'b1, 21'hA2, 1'b0);
        step(1'b0, 1'b1, 21'hA3, 1'b0);
        check_eq("stall_cnt", 32'(count), 32'd2);
        check_eq("stall_main", 32'(m_data), 32'hA1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, DW'($urandom), 1'b0);
            check_eq("hold_data", 32'(m_data), 32'hA1);
        end
        step(1'b0, 1'b1, 21'hA3, 1'b1);
        check_eq("rel_a2", 32'(m_data), 32'hA2);
        step(1'b0, 1'b1, 21'hA3, 1'b1);
        check_eq("rel_a3", 32'(m_data), 32'hA3);
        step(1'b0, 1'b0, 21'h0, 1'b1);

        // Single-beat drain
        step(1'b0, 1'b1, 21'h55, 1'b1);
        check_eq("drain_data", 32'(m_data), 32'h55);
        step(1'b0, 1'b0, 21'h0, 1'b1);
        check_eq("drain_empty", 32'(m_valid), 32'd0);

        // Reset while FULL discards both slots
        step(1'b0, 1'b1, 21'hB1, 1'b0);
        step(1'b0, 1'b1, 21'hB2, 1'b0);
        step(1'b1, 1'b0, 21'h0, 1'b1);
        check_eq("midrst_data", 32'(m_data), 32'(RSTV));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 21'h0, 1'b1);

        // Random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            held = DW'($urandom);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), held,
                 ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
